// File: rtl/count_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : count_display_driver
// Description : Converts the counter value to 3-digit BCD with a sequential
//               double-dabble engine and scans it onto a multiplexed
//               3-digit 7-segment display with optional leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module count_display_driver #(
    parameter int REFRESH_DIV = 1000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  value,
    output logic [11:0] bcd,
    output logic        bcd_valid,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    localparam int             DIV_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_ZERO  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } conv_state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Double-dabble converter
    // ------------------------------------------------------------------
    conv_state_t state_q, state_d;
    logic [7:0]  bin_q, bin_d;
    logic [11:0] work_q, work_d;
    logic [2:0]  iter_q, iter_d;
    logic [11:0] bcd_q, bcd_d;
    logic        bcd_valid_q, bcd_valid_d;
    logic [11:0] work_adj;

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        work_d      = work_q;
        iter_d      = iter_q;
        bcd_d       = bcd_q;
        bcd_valid_d = 1'b0;
        work_adj    = {add3(work_q[11:8]), add3(work_q[7:4]), add3(work_q[3:0])};

        case (state_q)
            ST_IDLE: begin
                bin_d   = value;
                work_d  = '0;
                iter_d  = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Correct nibbles first, then shift work:binary as one 20-bit word.
                {work_d, bin_d} = {work_adj[10:0], bin_q, 1'b0};
                iter_d          = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                bcd_d       = work_q;
                bcd_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bin_q       <= '0;
            work_q      <= '0;
            iter_q      <= '0;
            bcd_q       <= '0;
            bcd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            work_q      <= work_d;
            iter_q      <= iter_d;
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       idx_q, idx_d;
    logic [2:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             tick;
    logic [3:0]       digit_nib;
    logic             digit_blank;

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        div_d       = div_q + DIV_W'(1);
        idx_d       = idx_q;
        an_d        = an_q;
        seg_d       = seg_q;
        digit_nib   = 4'd0;
        digit_blank = 1'b0;

        if (tick) begin
            div_d = '0;
            idx_d = (idx_q == 2'd2) ? 2'd0 : (idx_q + 2'd1);

            // Segments come from bcd_q as it stands before this edge, so a
            // simultaneous conversion result appears from the next tick.
            case (idx_d)
                2'd0: begin
                    digit_nib = bcd_q[3:0];
                    an_d      = 3'b001;
                end
                2'd1: begin
                    digit_nib   = bcd_q[7:4];
                    digit_blank = BLANK_LZ && (bcd_q[11:4] == 8'd0);
                    an_d        = 3'b010;
                end
                2'd2: begin
                    digit_nib   = bcd_q[11:8];
                    digit_blank = BLANK_LZ && (bcd_q[11:8] == 4'd0);
                    an_d        = 3'b100;
                end
                default: begin
                    digit_nib = 4'd0;
                    an_d      = 3'b001;
                end
            endcase

            seg_d = digit_blank ? SEG_BLANK : seg_decode(digit_nib);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            idx_q <= 2'd0;
            an_q  <= 3'b001;
            seg_q <= SEG_ZERO;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign bcd       = bcd_q;
    assign bcd_valid = bcd_valid_q;
    assign seg       = seg_q;
    assign an        = an_q;

endmodule
`default_nettype wire

// File: tb/tb_count_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_display_driver
// Description : Directed self-checking bench for count_display_driver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_display_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  value;
    logic [11:0] bcd;
    logic        bcd_valid;
    logic [6:0]  seg;
    logic [2:0]  an;

    int n_checks = 0;
    int n_fail   = 0;

    count_display_driver #(
        .REFRESH_DIV (4),
        .BLANK_LZ    (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .value     (value),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .seg       (seg),
        .an        (an)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns number of steps until bcd_valid is seen, or -1 on timeout.
    task automatic wait_valid(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (bcd_valid === 1'b1) begin
                cyc = k;
                break;
            end
        end
    endtask

    // Returns number of steps until an changes, or -1 on timeout.
    task automatic wait_an_change(output int cyc);
        logic [2:0] prev;
        prev = an;
        cyc  = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (an !== prev) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int c;
        reset = 1'b1;
        value = 8'd77;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (bcd !== 12'h000) begin
                n_fail++; $display("FAIL reset_bcd got %h expected 000", bcd);
            end
            n_checks++;
            if (bcd_valid !== 1'b0) begin
                n_fail++; $display("FAIL reset_valid got %b expected 0", bcd_valid);
            end
            n_checks++;
            if (an !== 3'b001) begin
                n_fail++; $display("FAIL reset_an got %b expected 001", an);
            end
            n_checks++;
            if (seg !== 7'h3F) begin
                n_fail++; $display("FAIL reset_seg got %h expected 3f", seg);
            end
        end
        reset = 1'b0;
        wait_valid(c);
        n_checks++;
        if (c !== 10) begin
            n_fail++; $display("FAIL first_valid_latency got %0d expected 10", c);
        end
        n_checks++;
        if (bcd !== 12'h077) begin
            n_fail++; $display("FAIL first_bcd got %h expected 077", bcd);
        end
    endtask

    task automatic test_scan_255();
        int c;
        logic [2:0] prev_an;
        logic [6:0] exp_seg;
        value = 8'd255;
        wait_valid(c);
        wait_valid(c);
        n_checks++;
        if (bcd !== 12'h255) begin
            n_fail++; $display("FAIL bcd_255 got %h expected 255", bcd);
        end
        wait_an_change(c);
        n_checks++;
        if (c < 0) begin
            n_fail++; $display("FAIL scan_sync got timeout expected an change");
        end
        for (int i = 0; i < 3; i++) begin
            prev_an = an;
            wait_an_change(c);
            n_checks++;
            if (c !== 4) begin
                n_fail++; $display("FAIL scan_period got %0d expected 4", c);
            end
            n_checks++;
            if (an !== {prev_an[1:0], prev_an[2]}) begin
                n_fail++; $display("FAIL scan_order got %b expected %b", an, {prev_an[1:0], prev_an[2]});
            end
            exp_seg = (an == 3'b100) ? 7'h5B : 7'h6D;
            n_checks++;
            if (seg !== exp_seg) begin
                n_fail++; $display("FAIL scan_seg_255 an=%b got %h expected %h", an, seg, exp_seg);
            end
        end
    endtask

    task automatic test_sweep();
        int c;
        logic [11:0] exp;
        wait_valid(c);
        for (int v = 0; v < 256; v++) begin
            value = v[7:0];
            exp   = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
            wait_valid(c);
            n_checks++;
            if (c !== 10) begin
                n_fail++; $display("FAIL sweep_spacing v=%0d got %0d expected 10", v, c);
            end
            n_checks++;
            if (bcd !== exp) begin
                n_fail++; $display("FAIL sweep_bcd v=%0d got %h expected %h", v, bcd, exp);
            end
        end
    endtask

    task automatic test_blanking();
        int c;
        logic [6:0] exp_seg;
        wait_valid(c);
        value = 8'd7;
        wait_valid(c);
        n_checks++;
        if (bcd !== 12'h007) begin
            n_fail++; $display("FAIL blank_bcd7 got %h expected 007", bcd);
        end
        for (int i = 0; i < 3; i++) begin
            wait_an_change(c);
            case (an)
                3'b001:  exp_seg = 7'h07;
                3'b010:  exp_seg = 7'h00;
                3'b100:  exp_seg = 7'h00;
                default: exp_seg = 7'h7F;
            endcase
            n_checks++;
            if (c < 0 || seg !== exp_seg) begin
                n_fail++; $display("FAIL blank_seg7 an=%b got %h expected %h", an, seg, exp_seg);
            end
        end
        value = 8'd105;
        wait_valid(c);
        wait_valid(c);
        n_checks++;
        if (bcd !== 12'h105) begin
            n_fail++; $display("FAIL blank_bcd105 got %h expected 105", bcd);
        end
        for (int i = 0; i < 3; i++) begin
            wait_an_change(c);
            case (an)
                3'b001:  exp_seg = 7'h6D;
                3'b010:  exp_seg = 7'h3F;
                3'b100:  exp_seg = 7'h06;
                default: exp_seg = 7'h7F;
            endcase
            n_checks++;
            if (c < 0 || seg !== exp_seg) begin
                n_fail++; $display("FAIL blank_seg105 an=%b got %h expected %h", an, seg, exp_seg);
            end
        end
    endtask

    task automatic test_mid_shift_change();
        int c;
        wait_valid(c);
        value = 8'd12;
        step();
        step();
        step();
        value = 8'd200;
        wait_valid(c);
        n_checks++;
        if (c !== 7) begin
            n_fail++; $display("FAIL midshift_latency got %0d expected 7", c);
        end
        n_checks++;
        if (bcd !== 12'h012) begin
            n_fail++; $display("FAIL midshift_bcd got %h expected 012", bcd);
        end
        wait_valid(c);
        n_checks++;
        if (c !== 10 || bcd !== 12'h200) begin
            n_fail++; $display("FAIL midshift_next got bcd %h after %0d expected 200 after 10", bcd, c);
        end
    endtask

    task automatic test_reset_mid_conversion();
        int c;
        value = 8'd99;
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (bcd !== 12'h000) begin
            n_fail++; $display("FAIL midreset_bcd got %h expected 000", bcd);
        end
        n_checks++;
        if (an !== 3'b001 || seg !== 7'h3F) begin
            n_fail++; $display("FAIL midreset_display got an=%b seg=%h expected an=001 seg=3f", an, seg);
        end
        n_checks++;
        if (bcd_valid !== 1'b0) begin
            n_fail++; $display("FAIL midreset_valid got %b expected 0", bcd_valid);
        end
        wait_valid(c);
        n_checks++;
        if (c !== 10) begin
            n_fail++; $display("FAIL midreset_latency got %0d expected 10", c);
        end
        n_checks++;
        if (bcd !== 12'h099) begin
            n_fail++; $display("FAIL midreset_result got %h expected 099", bcd);
        end
    endtask

    initial begin
        reset = 1'b1;
        value = 8'd0;
        test_reset();
        test_scan_255();
        test_sweep();
        test_blanking();
        test_mid_shift_change();
        test_reset_mid_conversion();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
